// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   arb_state_e : arbiter FSM state codes (also exported on dbg_state)
//   MEM_W_*     : Mem_DcacheWidth encodings
package mem_port_arbiter_pkg;

  // ARB_ERR_D is the one-cycle response slot for a misaligned data access.
  // No bus transaction is issued on that path.
  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_REQ_I = 3'd1,
    ARB_REQ_D = 3'd2,
    ARB_RSP_I = 3'd3,
    ARB_RSP_D = 3'd4,
    ARB_ERR_D = 3'd5
  } arb_state_e;

  localparam logic [1:0] MEM_W_BYTE = 2'b00;
  localparam logic [1:0] MEM_W_HALF = 2'b01;
  localparam logic [1:0] MEM_W_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_be_gen.sv
// mem_be_gen: combinational byte-enable / store-lane generator.
//   width    in  access width (MEM_W_*)
//   addr_lo  in  byte offset within the word
//   data     in  LSB-justified store data
//   be       out byte enables for the bus word
//   wdata    out store data replicated across all lanes
//   misalign out access crosses its natural alignment (or width code unused)
module mem_be_gen
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            width,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misalign
);

  always_comb begin
    be       = 4'b0000;
    wdata    = data;
    misalign = 1'b0;
    case (width)
      MEM_W_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {(DATA_WIDTH/8){data[7:0]}};
      end
      MEM_W_HALF: begin
        be       = 4'b0011 << addr_lo;
        wdata    = {(DATA_WIDTH/16){data[15:0]}};
        misalign = addr_lo[0];
      end
      MEM_W_WORD: begin
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      // The unused width code is reported as an error rather than guessed at.
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch
// and Mem-stage data accesses, one transaction outstanding at a time.
// Data wins over fetch; a saturating starvation counter forces a fetch
// grant after STARVE_MAX consecutive data grants with fetch waiting.
//   If_*      fetch side: level request, kill/redirect, one-cycle valid
//   Mem_*     data side: level request, width/address/store data
//   D_*       data response: one-cycle valid, raw word, error flag
//   *_StallReq stall requests towards pipeline control
//   Bus_*     unified bus: request/grant address phase, rvalid response
//   dbg_state current FSM state
//
// Bus handshake: Bus_Req is held with Bus_Addr/We/Be/Wdata stable from the
// first REQ cycle until the cycle Bus_Gnt is high; that cycle transfers the
// address phase and a request is never withdrawn. Bus_Rvalid arrives at
// least one cycle after Bus_Gnt, is a one-cycle pulse, and Bus_Err/Rdata
// are only meaningful with it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  If_Req,
  input  logic [ADDR_WIDTH-1:0] If_Addr,
  input  logic                  If_Kill,
  output logic                  If_Valid,
  output logic [DATA_WIDTH-1:0] If_Rdata,
  output logic                  Icache_StallReq,
  input  logic                  Mem_DcacheEN,
  input  logic                  Mem_DcacheRd,
  input  logic [1:0]            Mem_DcacheWidth,
  input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
  input  logic [DATA_WIDTH-1:0] EXMem_Rs2Data,
  output logic                  D_Valid,
  output logic [DATA_WIDTH-1:0] D_Rdata,
  output logic                  D_Err,
  output logic                  Dcache_StallReq,
  output logic                  Bus_Req,
  output logic                  Bus_We,
  output logic [ADDR_WIDTH-1:0] Bus_Addr,
  output logic [3:0]            Bus_Be,
  output logic [DATA_WIDTH-1:0] Bus_Wdata,
  input  logic                  Bus_Gnt,
  input  logic                  Bus_Rvalid,
  input  logic [DATA_WIDTH-1:0] Bus_Rdata,
  input  logic                  Bus_Err,
  output arb_state_e            dbg_state
);

  localparam logic [CNT_W-1:0]      STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~ADDR_WIDTH'(3);

  arb_state_e            state, state_d;
  logic [CNT_W-1:0]      starve_cnt, starve_cnt_d;
  logic                  kill_pend, kill_pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [3:0]            gen_be;
  logic [DATA_WIDTH-1:0] gen_wdata;
  logic                  gen_mis;
  logic                  i_forced, pick_d, pick_i, d_done;

  mem_be_gen #(.DATA_WIDTH(DATA_WIDTH)) u_be_gen (
    .width    (Mem_DcacheWidth),
    .addr_lo  (Mem_DcacheAddr[1:0]),
    .data     (EXMem_Rs2Data),
    .be       (gen_be),
    .wdata    (gen_wdata),
    .misalign (gen_mis)
  );

  // Fetch is forced once it has watched STARVE_MAX data grants go by.
  // A killed fetch is not granted, even when forced.
  assign i_forced = If_Req & (starve_cnt == STARVE_LIM);
  assign pick_d   = Mem_DcacheEN & ~i_forced;
  assign pick_i   = ~pick_d & If_Req & ~If_Kill;

  always_comb begin
    state_d      = state;
    starve_cnt_d = starve_cnt;
    kill_pend_d  = kill_pend;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    case (state)
      ARB_IDLE: begin
        kill_pend_d = 1'b0;
        if (!If_Req) starve_cnt_d = '0;
        if (pick_d) begin
          if (If_Req && (starve_cnt != STARVE_LIM))
            starve_cnt_d = starve_cnt + CNT_W'(1);
          if (gen_mis) begin
            state_d = ARB_ERR_D;
          end else begin
            state_d = ARB_REQ_D;
            addr_d  = Mem_DcacheAddr & WORD_MASK;
            we_d    = ~Mem_DcacheRd;
            be_d    = gen_be;
            wdata_d = gen_wdata;
          end
        end else if (pick_i) begin
          state_d      = ARB_REQ_I;
          starve_cnt_d = '0;
          addr_d       = If_Addr & WORD_MASK;
          we_d         = 1'b0;
          be_d         = 4'b1111;
          wdata_d      = '0;
        end
      end
      ARB_REQ_I: begin
        if (If_Kill) kill_pend_d = 1'b1;
        if (Bus_Gnt) state_d = ARB_RSP_I;
      end
      ARB_RSP_I: begin
        if (If_Kill) kill_pend_d = 1'b1;
        if (Bus_Rvalid) state_d = ARB_IDLE;
      end
      ARB_REQ_D: if (Bus_Gnt) state_d = ARB_RSP_D;
      ARB_RSP_D: if (Bus_Rvalid) state_d = ARB_IDLE;
      ARB_ERR_D: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      kill_pend  <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_cnt_d;
      kill_pend  <= kill_pend_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
    end
  end

  assign Bus_Req   = (state == ARB_REQ_I) | (state == ARB_REQ_D);
  assign Bus_We    = we_q;
  assign Bus_Addr  = addr_q;
  assign Bus_Be    = be_q;
  assign Bus_Wdata = wdata_q;

  // A kill in the response cycle itself drops the response as well.
  assign If_Valid = (state == ARB_RSP_I) & Bus_Rvalid & ~kill_pend & ~If_Kill;
  assign If_Rdata = If_Valid ? Bus_Rdata : '0;

  assign d_done  = (state == ARB_RSP_D) & Bus_Rvalid;
  assign D_Valid = d_done | (state == ARB_ERR_D);
  assign D_Err   = (d_done & Bus_Err) | (state == ARB_ERR_D);
  assign D_Rdata = d_done ? Bus_Rdata : '0;

  // Stall requests are gated by reset so every output is quiet while held.
  assign Icache_StallReq = rst_n & If_Req & ~If_Valid & ~If_Kill;
  assign Dcache_StallReq = rst_n & Mem_DcacheEN & ~D_Valid;

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SBW = 71; // {chk_be, chk_wd, be[3:0], we, addr[31:0], wdata[31:0]}

  logic          clk, rst_n;
  logic          If_Req, If_Kill, If_Valid, Icache_StallReq;
  logic [AW-1:0] If_Addr;
  logic [DW-1:0] If_Rdata;
  logic          Mem_DcacheEN, Mem_DcacheRd;
  logic [1:0]    Mem_DcacheWidth;
  logic [AW-1:0] Mem_DcacheAddr;
  logic [DW-1:0] EXMem_Rs2Data;
  logic          D_Valid, D_Err, Dcache_StallReq;
  logic [DW-1:0] D_Rdata;
  logic          Bus_Req, Bus_We, Bus_Gnt, Bus_Rvalid, Bus_Err;
  logic [AW-1:0] Bus_Addr;
  logic [3:0]    Bus_Be;
  logic [DW-1:0] Bus_Wdata, Bus_Rdata;
  arb_state_e    dbg_state;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .If_Req(If_Req), .If_Addr(If_Addr), .If_Kill(If_Kill), .If_Valid(If_Valid),
    .If_Rdata(If_Rdata), .Icache_StallReq(Icache_StallReq),
    .Mem_DcacheEN(Mem_DcacheEN), .Mem_DcacheRd(Mem_DcacheRd), .Mem_DcacheWidth(Mem_DcacheWidth),
    .Mem_DcacheAddr(Mem_DcacheAddr), .EXMem_Rs2Data(EXMem_Rs2Data),
    .D_Valid(D_Valid), .D_Rdata(D_Rdata), .D_Err(D_Err), .Dcache_StallReq(Dcache_StallReq),
    .Bus_Req(Bus_Req), .Bus_We(Bus_We), .Bus_Addr(Bus_Addr), .Bus_Be(Bus_Be), .Bus_Wdata(Bus_Wdata),
    .Bus_Gnt(Bus_Gnt), .Bus_Rvalid(Bus_Rvalid), .Bus_Rdata(Bus_Rdata), .Bus_Err(Bus_Err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [SBW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop_compare(input string name);
    logic [SBW-1:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: bus request seen, got empty queue required an entry", name);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_addr"}, Bus_Addr, e[63:32]);
    check({name, "_we"}, Bus_We, e[64]);
    if (e[70]) check({name, "_be"}, Bus_Be, e[68:65]);
    if (e[69]) check({name, "_wdata"}, Bus_Wdata, e[31:0]);
  endtask

  task automatic wait_req(input string name, output logic ok);
    int cyc = 0;
    while (!Bus_Req && cyc < 8) begin
      @(negedge clk); #1;
      cyc++;
    end
    ok = Bus_Req;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: Bus_Req timeout got 0 required 1", name);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rd;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        mis;
    logic        berr;
  } vec_t;

  vec_t tbl[10];

  // ---------------- driver tasks ----------------
  task automatic d_access(input vec_t v, input int gdly, input int rdly, input logic [31:0] rdata);
    logic ok;
    @(negedge clk);
    Mem_DcacheEN = 1'b1; Mem_DcacheRd = v.rd; Mem_DcacheWidth = v.w;
    Mem_DcacheAddr = v.a; EXMem_Rs2Data = v.d;
    if (!v.mis) exp_q.push_back({1'b1, ~v.rd, v.be, ~v.rd, {v.a[31:2], 2'b00}, v.wd});
    #1;
    check("d_idle_noreq_stall", {Bus_Req, Dcache_StallReq}, 2'b01);
    @(negedge clk); #1;
    if (v.mis) begin
      check("mis_valid_err_noreq", {D_Valid, D_Err, Bus_Req}, 3'b110);
      check("mis_stall", Dcache_StallReq, 0);
    end else begin
      check("d_req_cycle2", Bus_Req, 1);
      wait_req("d_req", ok);
      if (ok) sb_pop_compare("d_bus");
      repeat (gdly) begin
        @(negedge clk); #1;
        check("d_req_held", {Bus_Req, Bus_Addr}, {1'b1, v.a[31:2], 2'b00});
      end
      Bus_Gnt = 1'b1;
      @(negedge clk); Bus_Gnt = 1'b0; #1;
      check("d_rsp_noreq", Bus_Req, 0);
      repeat (rdly) begin
        check("d_wait_novalid", {D_Valid, Dcache_StallReq}, 2'b01);
        @(negedge clk); #1;
      end
      Bus_Rvalid = 1'b1; Bus_Rdata = rdata; Bus_Err = v.berr; #1;
      check("d_valid_err", {D_Valid, D_Err}, {1'b1, v.berr});
      if (v.rd) check("d_rdata", D_Rdata, rdata);
      check("d_stall_drop", Dcache_StallReq, 0);
    end
    @(negedge clk); Bus_Rvalid = 1'b0; Bus_Err = 1'b0; Mem_DcacheEN = 1'b0; #1;
    check("d_valid_pulse", D_Valid, 0);
  endtask

  task automatic f_access(input string name, input logic [31:0] a, input int gdly,
                          input int rdly, input logic [31:0] rdata);
    logic ok;
    @(negedge clk);
    If_Req = 1'b1; If_Addr = a;
    exp_q.push_back({2'b00, 4'b0000, 1'b0, {a[31:2], 2'b00}, 32'h0});
    #1;
    check({name, "_idle"}, {Bus_Req, Icache_StallReq}, 2'b01);
    @(negedge clk); #1;
    check({name, "_req_cycle2"}, Bus_Req, 1);
    wait_req(name, ok);
    if (ok) sb_pop_compare(name);
    repeat (gdly) begin @(negedge clk); #1; check({name, "_req_held"}, Bus_Req, 1); end
    Bus_Gnt = 1'b1;
    @(negedge clk); Bus_Gnt = 1'b0; #1;
    repeat (rdly) begin
      check({name, "_wait"}, {If_Valid, Icache_StallReq}, 2'b01);
      @(negedge clk); #1;
    end
    Bus_Rvalid = 1'b1; Bus_Rdata = rdata; #1;
    check({name, "_valid_cycle3"}, {If_Valid, Icache_StallReq}, 2'b10);
    check({name, "_rdata"}, If_Rdata, rdata);
    @(negedge clk); Bus_Rvalid = 1'b0; If_Req = 1'b0; #1;
    check({name, "_valid_pulse"}, If_Valid, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic ok;
    rst_n = 1'b0; If_Req = 0; If_Kill = 0; If_Addr = '0;
    Mem_DcacheEN = 0; Mem_DcacheRd = 0; Mem_DcacheWidth = '0; Mem_DcacheAddr = '0; EXMem_Rs2Data = '0;
    Bus_Gnt = 0; Bus_Rvalid = 0; Bus_Rdata = '0; Bus_Err = 0;

    //          rd    w           a             d             be       wd            mis   berr
    tbl[0] = '{1'b0, MEM_W_BYTE, 32'h0000_0203, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, MEM_W_BYTE, 32'h0000_0200, 32'hFFFF_FF3C, 4'b0001, 32'h3C3C_3C3C, 1'b0, 1'b0};
    tbl[2] = '{1'b0, MEM_W_HALF, 32'h0000_0102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0};
    tbl[3] = '{1'b0, MEM_W_HALF, 32'h0000_0100, 32'h0000_5A5A, 4'b0011, 32'h5A5A_5A5A, 1'b0, 1'b0};
    tbl[4] = '{1'b0, MEM_W_WORD, 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[5] = '{1'b1, MEM_W_HALF, 32'h0000_0101, 32'h0,         4'b0000, 32'h0,         1'b1, 1'b0};
    tbl[6] = '{1'b1, MEM_W_WORD, 32'h0000_0302, 32'h0,         4'b0000, 32'h0,         1'b1, 1'b0};
    tbl[7] = '{1'b1, MEM_W_BYTE, 32'h0000_0041, 32'h0000_0077, 4'b0010, 32'h0,         1'b0, 1'b0};
    tbl[8] = '{1'b1, MEM_W_WORD, 32'h0000_0044, 32'h0,         4'b1111, 32'h0,         1'b0, 1'b1};
    tbl[9] = '{1'b0, MEM_W_WORD, 32'h0000_0006, 32'h1111_2222, 4'b0000, 32'h0,         1'b1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl_outs", {If_Valid, Icache_StallReq, D_Valid, D_Err, Dcache_StallReq, Bus_Req, Bus_We, Bus_Be}, 10'h0);
    check("rst_bus_fields", {Bus_Addr, Bus_Wdata}, 64'h0);
    check("rst_state", dbg_state, ARB_IDLE);
    @(negedge clk); rst_n = 1'b1;

    // Fetch only, minimum latency
    f_access("fetch1", 32'h100, 0, 0, 32'h0000_0013);

    // Data vectors (byte/half/word stores and loads, misaligned, bus error)
    for (int i = 0; i < 10; i++)
      d_access(tbl[i], $urandom_range(0, 2), $urandom_range(0, 3), $urandom);

    // Starvation: both requesters held every cycle; grants D,D,D,D,I,D
    @(negedge clk);
    If_Req = 1'b1; If_Addr = 32'h100;
    Mem_DcacheEN = 1'b1; Mem_DcacheRd = 1'b1; Mem_DcacheWidth = MEM_W_WORD; Mem_DcacheAddr = 32'h800;
    for (int t = 0; t < 6; t++)
      exp_q.push_back({2'b00, 4'b0000, 1'b0, (t == 4) ? 32'h100 : 32'h800, 32'h0});
    for (int t = 0; t < 6; t++) begin
      if (t > 0) begin @(negedge clk); Bus_Rvalid = 1'b0; end
      #1;
      check("starve_idle", {Bus_Req, Icache_StallReq}, {1'b0, (t <= 4) ? 1'b1 : 1'b1});
      @(negedge clk); Bus_Gnt = 1'b1; #1;
      check("starve_req", Bus_Req, 1);
      sb_pop_compare("starve_grant");
      if (t < 4) check("starve_istall_req", Icache_StallReq, 1);
      @(negedge clk); Bus_Gnt = 1'b0; Bus_Rvalid = 1'b1; Bus_Rdata = 32'h1000 + t; #1;
      if (t == 4) begin
        check("starve_i_valid", {If_Valid, D_Valid, Icache_StallReq}, 3'b100);
        check("starve_i_rdata", If_Rdata, 32'h1000 + t);
      end else begin
        check("starve_d_valid", {If_Valid, D_Valid}, 2'b01);
        if (t < 4) check("starve_istall", Icache_StallReq, 1);
      end
    end
    @(negedge clk); Bus_Rvalid = 1'b0; If_Req = 1'b0; Mem_DcacheEN = 1'b0; #1;

    // Kill during RSP_I with delayed response; redirected fetch follows
    @(negedge clk);
    If_Req = 1'b1; If_Addr = 32'h180;
    exp_q.push_back({2'b00, 4'b0000, 1'b0, 32'h180, 32'h0});
    #1;
    @(negedge clk); #1;
    wait_req("kill_req", ok);
    if (ok) sb_pop_compare("kill_bus");
    Bus_Gnt = 1'b1;
    @(negedge clk); Bus_Gnt = 1'b0; If_Kill = 1'b1; If_Addr = 32'h400; #1;
    check("kill_stall_drop", {If_Valid, Icache_StallReq}, 2'b00);
    @(negedge clk); If_Kill = 1'b0;
    exp_q.push_back({2'b00, 4'b0000, 1'b0, 32'h400, 32'h0});
    repeat (3) begin
      #1;
      check("kill_wait", {If_Valid, Icache_StallReq, Bus_Req}, 3'b010);
      @(negedge clk);
    end
    Bus_Rvalid = 1'b1; Bus_Rdata = 32'hBAD0_BAD0; #1;
    check("kill_suppressed", {If_Valid, Icache_StallReq}, 2'b01);
    @(negedge clk); Bus_Rvalid = 1'b0; #1;
    check("kill_next_idle", Bus_Req, 0);
    @(negedge clk); #1;
    check("kill_next_req", Bus_Req, 1);
    if (Bus_Req) sb_pop_compare("kill_next_bus");
    Bus_Gnt = 1'b1;
    @(negedge clk); Bus_Gnt = 1'b0; Bus_Rvalid = 1'b1; Bus_Rdata = 32'h0000_0400; #1;
    check("kill_next_valid", {If_Valid, If_Rdata}, {1'b1, 32'h0000_0400});
    @(negedge clk); Bus_Rvalid = 1'b0; If_Req = 1'b0; #1;

    // Kill in IDLE blocks the grant; kill together with Rvalid drops the response
    @(negedge clk); If_Req = 1'b1; If_Kill = 1'b1; If_Addr = 32'h500; #1;
    check("idle_kill_nostall", Icache_StallReq, 0);
    @(negedge clk); If_Kill = 1'b0;
    exp_q.push_back({2'b00, 4'b0000, 1'b0, 32'h500, 32'h0});
    #1;
    check("idle_kill_blocked", Bus_Req, 0);
    @(negedge clk); #1;
    check("idle_kill_then_req", Bus_Req, 1);
    if (Bus_Req) sb_pop_compare("idle_kill_bus");
    Bus_Gnt = 1'b1;
    @(negedge clk); Bus_Gnt = 1'b0; Bus_Rvalid = 1'b1; If_Kill = 1'b1; Bus_Rdata = 32'h5; #1;
    check("kill_same_cycle", If_Valid, 0);
    @(negedge clk); Bus_Rvalid = 1'b0; If_Kill = 1'b0; If_Req = 1'b0; #1;
    check("kill_same_cycle_idle", {If_Valid, Bus_Req}, 2'b00);

    // Asynchronous reset while in RSP_D
    @(negedge clk);
    Mem_DcacheEN = 1'b1; Mem_DcacheRd = 1'b1; Mem_DcacheWidth = MEM_W_WORD; Mem_DcacheAddr = 32'h900;
    exp_q.push_back({2'b10, 4'b1111, 1'b0, 32'h900, 32'h0});
    #1;
    @(negedge clk); #1;
    wait_req("rst_req", ok);
    if (ok) sb_pop_compare("rst_bus");
    Bus_Gnt = 1'b1;
    @(negedge clk); Bus_Gnt = 1'b0; #1;
    check("rst_pre_rspd", {Bus_Req, D_Valid, Dcache_StallReq}, 3'b001);
    #1; rst_n = 1'b0; If_Req = 1'b1; Bus_Rvalid = 1'b1; Bus_Rdata = 32'hFFFF_FFFF; Bus_Err = 1'b1;
    #1;
    check("arst_ctrl_outs", {If_Valid, Icache_StallReq, D_Valid, D_Err, Dcache_StallReq, Bus_Req, Bus_We, Bus_Be}, 10'h0);
    check("arst_rdata", {If_Rdata, D_Rdata}, 64'h0);
    check("arst_bus_fields", {Bus_Addr, Bus_Wdata}, 64'h0);
    @(negedge clk); Bus_Rvalid = 1'b0; Bus_Err = 1'b0; Mem_DcacheEN = 1'b0; If_Req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    f_access("post_rst_fetch", 32'h140, 1, 2, 32'h0000_0093);

    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
